// File: rtl/instruction_fetch_stage.sv
// MIPS32 IF stage: PC, next-PC select (seq/branch/jump) and IF/ID register; imem word reaches IF/ID 1 cycle after pc.
// stall holds PC and IF/ID; flush/redirect bubble IF/ID. Optional counters under IF_PERF_CNT_EN.
module instruction_fetch_stage #(
  parameter int                   MEM_WIDTH = 32,
  parameter logic [MEM_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [MEM_WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [MEM_WIDTH-1:0] imem_addr,
  input  logic [MEM_WIDTH-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_branch_taken,
  input  logic [15:0]          id_branch_off,
  input  logic                 id_jump,
  input  logic [25:0]          id_jump_index,
  output logic [MEM_WIDTH-1:0] pc_o,
  output logic [MEM_WIDTH-1:0] ifid_instr,
  output logic [MEM_WIDTH-1:0] ifid_pc_plus4,
  output logic                 ifid_valid,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
);

  logic [MEM_WIDTH-1:0] pc;
  logic [MEM_WIDTH-1:0] pc_plus4;
  logic [MEM_WIDTH-1:0] br_tgt;
  logic [MEM_WIDTH-1:0] jmp_tgt;
  logic [MEM_WIDTH-1:0] redirect_tgt;
  logic                 redirect;

  assign imem_addr    = pc;
  assign pc_o         = pc;
  assign pc_plus4     = pc + MEM_WIDTH'(4);
  assign br_tgt       = ifid_pc_plus4 + {{14{id_branch_off[15]}}, id_branch_off, 2'b00};
  assign jmp_tgt      = {ifid_pc_plus4[31:28], id_jump_index, 2'b00};
  // A bubble in IF/ID must never redirect, whatever ID drives.
  assign redirect     = ifid_valid & (id_jump | id_branch_taken);
  assign redirect_tgt = id_jump ? jmp_tgt : br_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      pc <= pc;
    end else if (redirect) begin
      // The word fetched this cycle is on the wrong path: squash it.
      pc         <= redirect_tgt;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_instr    <= imem_rdata;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush || (!stall && redirect)) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed pipeline scenarios then random traffic vs a reference model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall = 1'b0, flush = 1'b0, id_branch_taken = 1'b0, id_jump = 1'b0;
  logic [15:0] id_branch_off = '0;
  logic [25:0] id_jump_index = '0;
  logic [31:0] pc_o, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .MEM_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .id_branch_taken(id_branch_taken),
    .id_branch_off(id_branch_off), .id_jump(id_jump), .id_jump_index(id_jump_index),
    .pc_o(pc_o), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  // Instruction memory: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];

  // Architectural view of the stage.
  logic [31:0] m_pc = '0, m_instr = '0, m_pc4 = '0, m_sc = '0, m_fc = '0;
  logic        m_valid = 1'b0;

  task automatic model_edge(input bit r, input bit st, input bit fl, input bit br,
                            input logic [15:0] off, input bit j, input logic [25:0] idx);
    logic [31:0] tgt;
    bit          take;
    take = m_valid && (j || br);
    if (j) tgt = {m_pc4[31:28], idx, 2'b00};
    else   tgt = m_pc4 + 32'(int'($signed(off)) * 4);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    end else if (fl) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end else if (st) begin
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    end else if (take) begin
      m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit st, input bit fl, input bit br,
                      input logic [15:0] off, input bit j, input logic [25:0] idx);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl; id_branch_taken = br;
    id_branch_off = off; id_jump = j; id_jump_index = idx;
    model_edge(r, st, fl, br, off, j, idx);
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
`ifdef IF_PERF_CNT_EN
    e.scnt = m_sc; e.fcnt = m_fc;
`else
    e.scnt = 32'h0; e.fcnt = 32'h0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 0, 26'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every rising edge produces a new stage state; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
        chk("ifid_instr", ifid_instr, e.instr);
        if (e.valid) chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
        chk("perf_stall_cnt", perf_stall_cnt, e.scnt);
        chk("perf_flush_cnt", perf_flush_cnt, e.fcnt);
      end
    end
  end

  initial begin
    logic [15:0] off;
    bit r, st, fl, br, j;
    // Reset and sequential fetch.
    step(1, 0, 0, 0, 16'h0, 0, 26'h0);
    run(5);
    // Taken beq at 0x10 with offset -4 words -> 0x04, one bubble, then mem[0x04].
    step(0, 0, 0, 1, 16'hFFFC, 0, 26'h0);
    run(2);
    // Jump, then jump+branch together (jump wins).
    step(0, 0, 0, 0, 16'h0, 1, 26'h0000040);
    run(2);
    step(0, 0, 0, 1, 16'h0010, 1, 26'h0000080);
    run(2);
    // Branch to 0xFFFF_FFFC, then sequential wrap to 0.
    off = 16'((32'hFFFF_FFFC - m_pc4) >> 2);
    step(0, 0, 0, 1, off, 0, 26'h0);
    run(3);
    // Jump to 0x20, stall there, then stall+redirect and stall+flush.
    step(0, 0, 0, 0, 16'h0, 1, 26'h0000008);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0, 0, 26'h0);
    run(1);
    step(0, 1, 0, 1, 16'h0040, 1, 26'h0000100);
    step(0, 1, 0, 1, 16'h0040, 0, 26'h0);
    step(0, 1, 1, 1, 16'h0040, 0, 26'h0);
    run(2);
    step(1, 1, 0, 1, 16'h0040, 1, 26'h0000100);
    run(2);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      br = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 5) == 0);
      step(r, st, fl, br, 16'($urandom), j, 26'($urandom));
    end
    @(negedge clk);
    rst = 0; stall = 0; flush = 0; id_branch_taken = 0; id_jump = 0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
